// File: rtl/typedefs_pkg.sv
// Shared types and funct3 encodings for the load/store sequencer.
// access_error() holds the legality rules so the FSM stays readable.
package typedefs_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Stores only know sb/sh/sw; loads reject 3, 6 and 7. Size is funct3[1:0].
  function automatic logic access_error(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    bad_f3     = we ? (funct3 > F3_SW) : ((funct3 == 3'd3) || (funct3 > F3_LHU));
    misaligned = ((funct3[1:0] == 2'd1) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'd2) && (addr_lo != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_extender.sv
// Sign/zero extension of an already lane-shifted load word.
// Byte/half results come from the low bits of the word.
module load_extender
  import typedefs_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{word[7]}}, word[7:0]};
      F3_LH:   result = {{16{word[15]}}, word[15:0]};
      F3_LW:   result = word;
      F3_LBU:  result = {24'd0, word[7:0]};
      F3_LHU:  result = {16'd0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: validates a core request, drives the memory req/gnt/rvalid
// handshake with a timeout, and returns extended load data to the core.
module lsu_ctrl
  import typedefs_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [DWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [DWIDTH-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (DWIDTH != 32) begin : g_bad_dwidth
    $error("lsu_ctrl supports DWIDTH=32 only");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("lsu_ctrl requires TIMEOUT >= 2");
  end

  lsu_state_t        state_reg;
  logic              we_reg;
  logic [2:0]        f3_reg;
  logic [DWIDTH-1:0] addr_reg;
  logic [DWIDTH-1:0] wdata_reg;
  logic [DWIDTH-1:0] rdata_reg;
  logic              err_reg;
  logic [CW-1:0]     cnt_reg;

  logic [DWIDTH-1:0] shifted;
  logic [DWIDTH-1:0] ext_data;
  logic [3:0]        be;
  logic [DWIDTH-1:0] wdata_lanes;
  logic              timeout_hit;

  assign shifted     = mem_rdata >> {addr_reg[1:0], 3'b000};
  assign timeout_hit = (cnt_reg >= CW'(TIMEOUT - 1));

  load_extender u_ext (
    .word   (shifted),
    .funct3 (f3_reg),
    .result (ext_data)
  );

  always_comb begin
    be          = 4'b0000;
    wdata_lanes = wdata_reg;
    case (f3_reg)
      F3_SB: begin
        be          = 4'b0001 << addr_reg[1:0];
        wdata_lanes = {4{wdata_reg[7:0]}};
      end
      F3_SH: begin
        be          = addr_reg[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_reg[15:0]}};
      end
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    // Loads never assert byte enables.
    if (!we_reg) be = 4'b0000;
  end

  assign req_ready = (state_reg == IDLE);
  assign mem_req   = (state_reg == REQ);
  assign mem_addr  = {addr_reg[DWIDTH-1:2], 2'b00};
  assign mem_we    = we_reg;
  assign mem_be    = be;
  assign mem_wdata = wdata_lanes;
  assign rsp_valid = (state_reg == RSP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      f3_reg    <= 3'd0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            f3_reg    <= req_funct3;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            rdata_reg <= '0;
            cnt_reg   <= '0;
            if (access_error(req_we, req_funct3, req_addr[1:0])) begin
              err_reg   <= 1'b1;
              state_reg <= RSP;
            end else begin
              err_reg   <= 1'b0;
              state_reg <= REQ;
            end
          end
        end
        REQ: begin
          // A grant in the timeout cycle still wins.
          if (mem_gnt) begin
            cnt_reg   <= cnt_reg + CW'(1);
            state_reg <= WAIT;
          end else if (timeout_hit) begin
            err_reg   <= 1'b1;
            state_reg <= RSP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_reg <= we_reg ? '0 : ext_data;
            state_reg <= RSP;
          end else if (timeout_hit) begin
            err_reg   <= 1'b1;
            state_reg <= RSP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RSP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized transactions
// compared against a byte-lane reference model.
module tb_lsu_ctrl;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  lsu_ctrl #(.DWIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  int errors = 0;
  int checks = 0;

  int          obs_reqc, obs_lat, obs_req_unstable, obs_hold_bad;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_we, obs_err, obs_ready_in_rsp, obs_ready_after, obs_hung;

  // Reference: byte lanes of an access of 2**funct3[1:0] bytes starting at addr%4.
  task automatic exp_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           output logic e_err, output logic [3:0] e_be,
                           output logic [31:0] e_wd, output logic [31:0] e_rd);
    int nb, off;
    logic legal;
    nb    = 1 << f3[1:0];
    off   = int'(addr % 4);
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    e_err = !legal || ((addr % nb) != 0);
    e_be  = 4'b0000;
    e_wd  = 32'd0;
    e_rd  = 32'd0;
    if (!e_err && we) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nb) e_be[i] = 1'b1;
        e_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
      end
    end
    if (!e_err && !we) begin
      for (int i = 0; i < nb; i++) e_rd[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (!f3[2] && nb < 4 && e_rd[8*nb-1])
        for (int i = nb; i < 4; i++) e_rd[8*i +: 8] = 8'hFF;
    end
  endtask

  // Drives one request and records what the DUT did; the test tasks judge it.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly, input int rdy_dly);
    int cyc, waitc;
    bit gnt_given;
    obs_hung = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    if (!req_ready) obs_hung = 1'b1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom(); req_funct3 = 3'($urandom());
    obs_reqc = 0; obs_req_unstable = 0; waitc = 0; gnt_given = 1'b0; cyc = 0;
    obs_addr = 32'd0; obs_wdata = 32'd0; obs_be = 4'd0; obs_we = 1'b0;
    while (!rsp_valid && cyc < TO + 40) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom();
      if (mem_req) begin
        if (obs_reqc == 0) begin
          obs_addr = mem_addr; obs_wdata = mem_wdata; obs_be = mem_be; obs_we = mem_we;
        end else if (mem_addr !== obs_addr || mem_wdata !== obs_wdata ||
                     mem_be !== obs_be || mem_we !== obs_we) begin
          obs_req_unstable++;
        end
        if (obs_reqc == gnt_dly) begin mem_gnt = 1'b1; gnt_given = 1'b1; end
        obs_reqc++;
      end else if (gnt_given) begin
        if (waitc == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        waitc++;
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    obs_lat = cyc;
    if (!rsp_valid) obs_hung = 1'b1;
    obs_err = rsp_err; obs_rdata = rsp_rdata; obs_hold_bad = 0;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_err !== obs_err || rsp_rdata !== obs_rdata || req_ready !== 1'b0)
        obs_hold_bad++;
    end
    obs_ready_in_rsp = req_ready;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    obs_ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++; if ({mem_req, mem_we, mem_be, rsp_valid, rsp_err} !== 8'd0) begin errors++;
      $display("FAIL reset_ctrl got=%b want=0", {mem_req, mem_we, mem_be, rsp_valid, rsp_err}); end
    checks++; if ({mem_addr, mem_wdata, rsp_rdata} !== 96'd0) begin errors++;
      $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, rsp_rdata}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lbu();
    run_txn(1'b0, 3'd4, 32'h103, 32'h1111_2222, 32'h80FF_1234, 1, 1, 0);
    $display("lbu addr=0x103 rdata=%h err=%b", obs_rdata, obs_err);
    checks++; if (obs_hung) begin errors++; $display("FAIL lbu_timeout got=hung want=response"); end
    checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL lbu_addr got=%h want=00000100", obs_addr); end
    checks++; if ({obs_we, obs_be} !== 5'd0) begin errors++; $display("FAIL lbu_we_be got=%b want=00000", {obs_we, obs_be}); end
    checks++; if (obs_rdata !== 32'h80 || obs_err !== 1'b0) begin errors++;
      $display("FAIL lbu_rsp got=%h/%b want=00000080/0", obs_rdata, obs_err); end
    checks++; if (obs_reqc !== 2 || obs_lat !== 4) begin errors++;
      $display("FAIL lbu_timing got=req%0d/lat%0d want=req2/lat4", obs_reqc, obs_lat); end
  endtask

  task automatic test_sh_store();
    run_txn(1'b1, 3'd1, 32'h22, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, 0);
    $display("sh addr=0x22 be=%b wdata=%h err=%b", obs_be, obs_wdata, obs_err);
    checks++; if (obs_be !== 4'b1100 || obs_we !== 1'b1) begin errors++;
      $display("FAIL sh_be got=%b/%b want=1100/1", obs_be, obs_we); end
    checks++; if (obs_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got=%h want=beefbeef", obs_wdata); end
    checks++; if (obs_rdata !== 32'd0 || obs_err !== 1'b0 || obs_hung) begin errors++;
      $display("FAIL sh_rsp got=%h/%b want=00000000/0", obs_rdata, obs_err); end
  endtask

  task automatic test_illegal();
    run_txn(1'b0, 3'd2, 32'h6, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
    $display("lw addr=0x6 err=%b reqs=%0d", obs_err, obs_reqc);
    checks++; if (obs_reqc !== 0 || obs_lat !== 0 || obs_err !== 1'b1 || obs_rdata !== 32'd0) begin errors++;
      $display("FAIL misaligned_lw got=req%0d/lat%0d/err%b want=req0/lat0/err1", obs_reqc, obs_lat, obs_err); end
    run_txn(1'b0, 3'd3, 32'h0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
    $display("ld f3=3 err=%b reqs=%0d", obs_err, obs_reqc);
    checks++; if (obs_reqc !== 0 || obs_lat !== 0 || obs_err !== 1'b1 || obs_rdata !== 32'd0) begin errors++;
      $display("FAIL illegal_f3 got=req%0d/lat%0d/err%b want=req0/lat0/err1", obs_reqc, obs_lat, obs_err); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'd0, 32'h1, 32'd0, 32'd0, 100000, 0, 0);
    $display("lb timeout reqs=%0d err=%b", obs_reqc, obs_err);
    checks++; if (obs_reqc !== TO || obs_lat !== TO) begin errors++;
      $display("FAIL timeout_len got=req%0d/lat%0d want=%0d", obs_reqc, obs_lat, TO); end
    checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'd0) begin errors++;
      $display("FAIL timeout_err got=%b/%h want=1/0", obs_err, obs_rdata); end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin errors++;
      $display("FAIL stray_rvalid got=%b%b%b want=010", rsp_valid, req_ready, mem_req); end
  endtask

  task automatic test_backpressure();
    run_txn(1'b0, 3'd1, 32'h2, 32'd0, 32'h8001_0000, 0, 0, 3);
    $display("lh addr=0x2 rdata=%h held_bad=%0d", obs_rdata, obs_hold_bad);
    checks++; if (obs_rdata !== 32'hFFFF_8001 || obs_err !== 1'b0) begin errors++;
      $display("FAIL bp_rdata got=%h/%b want=ffff8001/0", obs_rdata, obs_err); end
    checks++; if (obs_hold_bad !== 0 || obs_ready_in_rsp !== 1'b0) begin errors++;
      $display("FAIL bp_hold got=%0d/%b want=0/0", obs_hold_bad, obs_ready_in_rsp); end
    checks++; if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%b want=1", obs_ready_after); end
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if ({mem_req, rsp_valid, req_ready} !== 3'b000) begin errors++;
      $display("FAIL wait_state got=%b want=000", {mem_req, rsp_valid, req_ready}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin errors++;
      $display("FAIL async_reset got=%b want=001", {mem_req, rsp_valid, req_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 3'd2, 32'h44, 32'd0, 32'h1234_5678, 0, 1, 0);
    $display("lw after reset rdata=%h err=%b", obs_rdata, obs_err);
    checks++; if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0 || obs_hung) begin errors++;
      $display("FAIL post_reset_txn got=%h/%b want=12345678/0", obs_rdata, obs_err); end
  endtask

  task automatic test_random();
    logic        we, e_err;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd, e_wd, e_rd;
    logic [3:0]  e_be;
    int          gd, rv, rdy;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom()); f3 = 3'($urandom()); addr = $urandom(); wd = $urandom(); rd = $urandom();
      if ($urandom_range(0, 1) == 1) addr[1:0] = addr[1:0] & ~(2'(f3[1:0] == 2'd1 ? 1 : (f3[1:0] == 2'd0 ? 0 : 3)));
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 3); rdy = $urandom_range(0, 2);
      exp_model(we, f3, addr, wd, rd, e_err, e_be, e_wd, e_rd);
      run_txn(we, f3, addr, wd, rd, gd, rv, rdy);
      $display("txn %0d we=%b f3=%0d addr=%h err=%b rdata=%h", n, we, f3, addr, obs_err, obs_rdata);
      checks++; if (obs_err !== e_err || obs_rdata !== e_rd || obs_hung) begin errors++;
        $display("FAIL rnd_rsp n=%0d got=%b/%h want=%b/%h", n, obs_err, obs_rdata, e_err, e_rd); end
      checks++; if (obs_reqc !== (e_err ? 0 : gd + 1) || obs_lat !== (e_err ? 0 : gd + rv + 2)) begin errors++;
        $display("FAIL rnd_timing n=%0d got=req%0d/lat%0d want=req%0d/lat%0d", n, obs_reqc, obs_lat,
                 e_err ? 0 : gd + 1, e_err ? 0 : gd + rv + 2); end
      if (!e_err) begin
        checks++; if (obs_addr !== {addr[31:2], 2'b00} || obs_we !== we || obs_be !== e_be) begin errors++;
          $display("FAIL rnd_mem n=%0d got=%h/%b/%b want=%h/%b/%b", n, obs_addr, obs_we, obs_be,
                   {addr[31:2], 2'b00}, we, e_be); end
        if (we) begin
          checks++; if (obs_wdata !== e_wd) begin errors++;
            $display("FAIL rnd_wdata n=%0d got=%h want=%h", n, obs_wdata, e_wd); end
        end
        checks++; if (obs_req_unstable !== 0) begin errors++;
          $display("FAIL rnd_stable n=%0d got=%0d want=0", n, obs_req_unstable); end
      end
      checks++; if (obs_hold_bad !== 0 || obs_ready_after !== 1'b1) begin errors++;
        $display("FAIL rnd_hs n=%0d got=%0d/%b want=0/1", n, obs_hold_bad, obs_ready_after); end
    end
  endtask

  initial begin
    test_reset();
    test_lbu();
    test_sh_store();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
